// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data memory) arbiter onto a single RAM port with ack timeout.
// Define MEM_ARBITER_RR_EN for round-robin on simultaneous requests; default is fixed ME-over-IF.
//
// state  | meaning
// IDLE   | no access in flight; requests sampled and arbitrated here
// ACCESS | command presented to RAM, waiting for ram_ack_i or timeout
// DONE   | single-cycle completion: owner's done pulse, read data, optional err_o
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        if_r_enable_i,
    input  logic [31:0] if_addr_i,
    output logic        if_busy_o,
    output logic        if_done_o,
    output logic [31:0] if_r_data_o,

    input  logic        me_r_enable_i,
    input  logic        me_w_enable_i,
    input  logic [31:0] me_addr_i,
    input  logic [31:0] me_w_data_i,
    input  logic [3:0]  me_w_mask_i,
    output logic        me_busy_o,
    output logic        me_done_o,
    output logic [31:0] me_r_data_o,

    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_w_data_o,
    output logic [3:0]  ram_w_mask_o,
    input  logic        ram_ack_i,
    input  logic [31:0] ram_r_data_i,

    output logic        err_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic        OWN_IF    = 1'b0;
    localparam logic        OWN_ME    = 1'b1;
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    state_t      state;
    state_t      state_nxt;
    logic        owner;
    logic [15:0] wait_cnt;
    logic [31:0] rd_data_q;
    logic        timeout_q;
    logic        ram_we_q;
    logic [31:0] ram_addr_q;
    logic [31:0] ram_w_data_q;
    logic [3:0]  ram_w_mask_q;

    logic        if_req;
    logic        me_req;
    logic        grant;
    logic        grant_me;
    logic        wait_expired;

    assign if_req       = if_r_enable_i;
    assign me_req       = me_r_enable_i | me_w_enable_i;
    assign grant        = (state == ST_IDLE) && (if_req || me_req);
    assign wait_expired = (wait_cnt == WAIT_LAST);

`ifdef MEM_ARBITER_RR_EN
    logic last_me;

    // On contention the port that did not win last time is served.
    assign grant_me = me_req && (!if_req || !last_me);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_me <= OWN_IF;
        end else if (grant) begin
            last_me <= grant_me;
        end
    end
`else
    assign grant_me = me_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (if_req || me_req) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (ram_ack_i || wait_expired) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Command fields are latched at grant so requesters may move on during ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner        <= OWN_ME;
            wait_cnt     <= '0;
            rd_data_q    <= '0;
            timeout_q    <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_w_data_q <= '0;
            ram_w_mask_q <= '0;
        end else if (grant) begin
            owner     <= grant_me;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
            if (grant_me && me_w_enable_i) begin
                ram_we_q     <= 1'b1;
                ram_addr_q   <= me_addr_i;
                ram_w_data_q <= me_w_data_i;
                ram_w_mask_q <= me_w_mask_i;
            end else if (grant_me) begin
                ram_we_q     <= 1'b0;
                ram_addr_q   <= me_addr_i & WORD_MASK;
                ram_w_data_q <= '0;
                ram_w_mask_q <= '0;
            end else begin
                ram_we_q     <= 1'b0;
                ram_addr_q   <= if_addr_i & WORD_MASK;
                ram_w_data_q <= '0;
                ram_w_mask_q <= '0;
            end
        end else if (state == ST_ACCESS) begin
            // Ack takes precedence over an expiring wait in the same cycle.
            if (ram_ack_i) begin
                rd_data_q <= ram_r_data_i;
            end else if (wait_expired) begin
                rd_data_q <= '0;
                timeout_q <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        ram_req_o    = (state == ST_ACCESS);
        ram_we_o     = ram_we_q;
        ram_addr_o   = ram_addr_q;
        ram_w_data_o = ram_w_data_q;
        ram_w_mask_o = ram_w_mask_q;
        if_busy_o    = (state != ST_IDLE);
        me_busy_o    = (state != ST_IDLE);
        if_done_o    = (state == ST_DONE) && (owner == OWN_IF);
        me_done_o    = (state == ST_DONE) && (owner == OWN_ME);
        if_r_data_o  = '0;
        me_r_data_o  = '0;
        err_o        = (state == ST_DONE) && timeout_q;
        if (state == ST_DONE) begin
            if (owner == OWN_ME) begin
                me_r_data_o = rd_data_q;
            end else begin
                if_r_data_o = rd_data_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: transaction-level reference model feeds expectation queues,
// a separate monitor compares RAM commands and completions; RAM responder with random latency.
module tb_mem_arbiter;

    localparam int T = 4;

    logic        clk;
    logic        rst_n;
    logic        if_r_enable_i;
    logic [31:0] if_addr_i;
    logic        if_busy_o;
    logic        if_done_o;
    logic [31:0] if_r_data_o;
    logic        me_r_enable_i;
    logic        me_w_enable_i;
    logic [31:0] me_addr_i;
    logic [31:0] me_w_data_i;
    logic [3:0]  me_w_mask_i;
    logic        me_busy_o;
    logic        me_done_o;
    logic [31:0] me_r_data_o;
    logic        ram_req_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_w_data_o;
    logic [3:0]  ram_w_mask_o;
    logic        ram_ack_i;
    logic [31:0] ram_r_data_i;
    logic        err_o;

    mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_r_enable_i(if_r_enable_i),
        .if_addr_i    (if_addr_i),
        .if_busy_o    (if_busy_o),
        .if_done_o    (if_done_o),
        .if_r_data_o  (if_r_data_o),
        .me_r_enable_i(me_r_enable_i),
        .me_w_enable_i(me_w_enable_i),
        .me_addr_i    (me_addr_i),
        .me_w_data_i  (me_w_data_i),
        .me_w_mask_i  (me_w_mask_i),
        .me_busy_o    (me_busy_o),
        .me_done_o    (me_done_o),
        .me_r_data_o  (me_r_data_o),
        .ram_req_o    (ram_req_o),
        .ram_we_o     (ram_we_o),
        .ram_addr_o   (ram_addr_o),
        .ram_w_data_o (ram_w_data_o),
        .ram_w_mask_o (ram_w_mask_o),
        .ram_ack_i    (ram_ack_i),
        .ram_r_data_i (ram_r_data_i),
        .err_o        (err_o)
    );

    typedef struct {
        bit          own_me;
        logic [31:0] addr;
        bit          we;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        bit          own_me;
        logic [31:0] rdata;
        bit          err;
    } done_t;

    cmd_t        cmd_q[$];
    done_t       done_q[$];
    int          n_checks;
    int          n_pass;
    bit          model_en;
    bit          mon_en;
    int          forced_lat;
    bit          force_data_en;
    logic [31:0] forced_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time, arbitration computed from the pending set.
    initial begin : model
        bit    last_me;
        bit    sel_me;
        bit    fin;
        int    n;
        cmd_t  c;
        done_t d;
        last_me = 1'b0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                last_me = 1'b0;
            end else if (model_en && (if_r_enable_i || me_r_enable_i || me_w_enable_i)) begin
                if ((me_r_enable_i || me_w_enable_i) && if_r_enable_i) begin
`ifdef MEM_ARBITER_RR_EN
                    sel_me = !last_me;
`else
                    sel_me = 1'b1;
`endif
                end else begin
                    sel_me = me_r_enable_i || me_w_enable_i;
                end
                last_me  = sel_me;
                c.own_me = sel_me;
                if (sel_me && me_w_enable_i) begin
                    c.addr  = me_addr_i;
                    c.we    = 1'b1;
                    c.mask  = me_w_mask_i;
                    c.wdata = me_w_data_i;
                end else begin
                    c.addr  = (sel_me ? me_addr_i : if_addr_i) / 4 * 4;
                    c.we    = 1'b0;
                    c.mask  = 4'b0000;
                    c.wdata = 32'h0;
                end
                cmd_q.push_back(c);
                n   = 0;
                fin = 1'b0;
                while (!fin) begin
                    @(posedge clk);
                    if (ram_ack_i) begin
                        d.own_me = sel_me;
                        d.rdata  = ram_r_data_i;
                        d.err    = 1'b0;
                        fin      = 1'b1;
                    end else if (n == T - 1) begin
                        d.own_me = sel_me;
                        d.rdata  = 32'h0;
                        d.err    = 1'b1;
                        fin      = 1'b1;
                    end else begin
                        n++;
                    end
                end
                done_q.push_back(d);
                @(posedge clk);
            end
        end
    end

    // RAM responder: ack after a chosen number of ACCESS cycles, stray acks while idle.
    initial begin : responder
        bit in_acc;
        bit ack_sent;
        int lat_cnt;
        int target;
        ram_ack_i    = 1'b0;
        ram_r_data_i = 32'h0;
        in_acc       = 1'b0;
        ack_sent     = 1'b0;
        lat_cnt      = 0;
        target       = 0;
        forever begin
            @(negedge clk);
            ram_ack_i = 1'b0;
            if (ram_req_o) begin
                if (!in_acc) begin
                    in_acc   = 1'b1;
                    ack_sent = 1'b0;
                    lat_cnt  = 0;
                    target   = (forced_lat >= 0) ? forced_lat : int'($urandom_range(0, 5));
                end
                if (!ack_sent && lat_cnt == target) begin
                    ram_ack_i    = 1'b1;
                    ram_r_data_i = force_data_en ? forced_data : $urandom;
                    ack_sent     = 1'b1;
                end
                lat_cnt++;
            end else begin
                in_acc = 1'b0;
                if ($urandom_range(0, 3) == 0) begin
                    ram_ack_i    = 1'b1;
                    ram_r_data_i = $urandom;
                end
            end
        end
    end

    // Monitor: pops expectations when the DUT presents a command or a completion.
    initial begin : monitor
        bit    prev_req;
        bit    have_cmd;
        cmd_t  cur;
        done_t e;
        prev_req = 1'b0;
        have_cmd = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (ram_req_o) begin
                    if (!prev_req) begin
                        if (cmd_q.size() == 0) begin
                            chk("unexpected_ram_req", 32'd1, 32'd0);
                            have_cmd = 1'b0;
                        end else begin
                            cur      = cmd_q.pop_front();
                            have_cmd = 1'b1;
                        end
                    end
                    if (have_cmd) begin
                        chk("ram_addr", ram_addr_o, cur.addr);
                        chk("ram_we", ram_we_o, cur.we);
                        chk("ram_mask", ram_w_mask_o, cur.mask);
                        if (cur.we || !cur.own_me) begin
                            chk("ram_wdata", ram_w_data_o, cur.wdata);
                        end
                    end
                end
                if (if_done_o || me_done_o || err_o) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = done_q.pop_front();
                        chk("if_done", if_done_o, !e.own_me);
                        chk("me_done", me_done_o, e.own_me);
                        chk("err", err_o, e.err);
                        chk("rdata_owner", e.own_me ? me_r_data_o : if_r_data_o, e.rdata);
                        chk("rdata_other", e.own_me ? if_r_data_o : me_r_data_o, 32'h0);
                    end
                end else begin
                    chk("rdata_not_done", if_r_data_o | me_r_data_o, 32'h0);
                end
            end
            prev_req = ram_req_o;
        end
    end

    task automatic do_round(input bit di, input bit dm, input bit mw, input bit mr,
                            input logic [31:0] ia, input logic [31:0] ma,
                            input logic [31:0] md, input logic [3:0] mk,
                            input int lat, input bit fd, input logic [31:0] fdata);
        int guard;
        @(negedge clk);
        forced_lat    = lat;
        force_data_en = fd;
        forced_data   = fdata;
        if_addr_i     = ia;
        me_addr_i     = ma;
        me_w_data_i   = md;
        me_w_mask_i   = mk;
        if_r_enable_i = di;
        me_r_enable_i = dm && mr;
        me_w_enable_i = dm && mw;
        guard = 0;
        while ((if_r_enable_i || me_r_enable_i || me_w_enable_i) && guard < 100) begin
            @(negedge clk);
            guard++;
            if (if_done_o) if_r_enable_i = 1'b0;
            if (me_done_o) begin
                me_r_enable_i = 1'b0;
                me_w_enable_i = 1'b0;
            end
            if (ram_req_o && $urandom_range(0, 1) == 1) begin
                if_addr_i   = $urandom;
                me_addr_i   = $urandom;
                me_w_data_i = $urandom;
                me_w_mask_i = 4'($urandom_range(0, 15));
            end
        end
        if (guard >= 100) begin
            chk("round_completion_timeout", 32'd0, 32'd1);
            if_r_enable_i = 1'b0;
            me_r_enable_i = 1'b0;
            me_w_enable_i = 1'b0;
        end
    endtask

    initial begin
        bit mw;
        bit mr;
        int kind;
        n_checks      = 0;
        n_pass        = 0;
        model_en      = 1'b0;
        mon_en        = 1'b0;
        forced_lat    = -1;
        force_data_en = 1'b0;
        forced_data   = 32'h0;
        rst_n         = 1'b0;
        if_r_enable_i = 1'b0;
        if_addr_i     = 32'h0;
        me_r_enable_i = 1'b0;
        me_w_enable_i = 1'b0;
        me_addr_i     = 32'h0;
        me_w_data_i   = 32'h0;
        me_w_mask_i   = 4'h0;

        #12;
        chk("rst_ram_req", ram_req_o, 0);
        chk("rst_ram_we", ram_we_o, 0);
        chk("rst_ram_addr", ram_addr_o, 0);
        chk("rst_ram_wdata", ram_w_data_o, 0);
        chk("rst_ram_mask", ram_w_mask_o, 0);
        chk("rst_if_busy", if_busy_o, 0);
        chk("rst_me_busy", me_busy_o, 0);
        chk("rst_if_done", if_done_o, 0);
        chk("rst_me_done", me_done_o, 0);
        chk("rst_if_rdata", if_r_data_o, 0);
        chk("rst_me_rdata", me_r_data_o, 0);
        chk("rst_err", err_o, 0);

        @(negedge clk);
        rst_n    = 1'b1;
        model_en = 1'b1;
        mon_en   = 1'b1;

        // Contention, held: grant order depends on arbitration policy.
        repeat (3) do_round(1, 1, 0, 1, 32'h0000_0100, 32'h0000_0203, 32'h0, 4'h0, 0, 0, 32'h0);
        // Lone fetch, unaligned, ack on the last wait cycle.
        do_round(1, 0, 0, 0, 32'h0000_1006, 32'h0, 32'h0, 4'h0, 3, 1, 32'hDEAD_BEEF);
        // Store with partial byte mask.
        do_round(0, 1, 1, 0, 32'h0, 32'h0000_0020, 32'h1122_3344, 4'b1100, 1, 0, 32'h0);
        // Read and write both asserted is a write.
        do_round(0, 1, 1, 1, 32'h0, 32'h0000_0047, 32'hCAFE_F00D, 4'b0101, 0, 0, 32'h0);
        // No ack: timeout abort for each owner.
        do_round(1, 0, 0, 0, 32'h0000_3000, 32'h0, 32'h0, 4'h0, 100, 0, 32'h0);
        do_round(0, 1, 0, 1, 32'h0, 32'h0000_4001, 32'h0, 4'h0, 100, 0, 32'h0);

        for (int i = 0; i < 200; i++) begin
            kind = int'($urandom_range(0, 2));
            mw   = 1'($urandom_range(0, 1));
            mr   = mw ? 1'($urandom_range(0, 1)) : 1'b1;
            do_round(kind != 1, kind != 0, mw, mr, $urandom, $urandom, $urandom,
                     4'($urandom_range(0, 15)), -1, 0, 32'h0);
        end

        repeat (5) @(negedge clk);
        chk("cmd_q_drained", cmd_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        model_en = 1'b0;
        mon_en   = 1'b0;

        // Reset in the middle of an access abandons it without a completion.
        @(negedge clk);
        forced_lat    = 100;
        if_addr_i     = 32'h0000_0040;
        if_r_enable_i = 1'b1;
        @(negedge clk);
        chk("pre_rst_ram_req", ram_req_o, 1);
        chk("pre_rst_if_busy", if_busy_o, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ram_req", ram_req_o, 0);
        chk("mid_rst_if_busy", if_busy_o, 0);
        chk("mid_rst_me_busy", me_busy_o, 0);
        chk("mid_rst_ram_addr", ram_addr_o, 0);
        if_r_enable_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_done", {30'h0, if_done_o, me_done_o}, 0);
        end
        rst_n         = 1'b1;
        forced_lat    = 0;
        me_addr_i     = 32'h0000_0084;
        me_w_data_i   = 32'hA5A5_0001;
        me_w_mask_i   = 4'b0011;
        me_w_enable_i = 1'b1;
        @(negedge clk);
        chk("post_rst_ram_req", ram_req_o, 1);
        chk("post_rst_ram_we", ram_we_o, 1);
        chk("post_rst_ram_addr", ram_addr_o, 32'h0000_0084);
        chk("post_rst_ram_wdata", ram_w_data_o, 32'hA5A5_0001);
        chk("post_rst_ram_mask", ram_w_mask_o, 4'b0011);
        @(negedge clk);
        chk("post_rst_me_done", me_done_o, 1);
        chk("post_rst_if_done", if_done_o, 0);
        chk("post_rst_err", err_o, 0);
        me_w_enable_i = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
